// File: rtl/servo_pkg.sv
// Shared constants and types for the roll-to-servo PWM path.
package servo_pkg;

    localparam int PERIOD_CYCLES_DEF   = 960_000;
    localparam int CENTER_CYCLES_DEF   = 72_000;
    localparam int GAIN_DEF            = 11;
    localparam int ROLL_LIM_DEF        = 2047;
    localparam int TIMEOUT_PERIODS_DEF = 25;

    localparam int CNT_W   = 20;
    localparam int WIDTH_W = 22;

    typedef logic signed [15:0] roll_t;

    // Symmetric clamp of a signed roll word to +/-lim.
    function automatic roll_t clamp_roll(input roll_t r, input int lim);
        roll_t c;
        if (r > lim)
            c = roll_t'(lim);
        else if (r < -lim)
            c = roll_t'(-lim);
        else
            c = r;
        return c;
    endfunction

endpackage

// File: rtl/roll_servo_pwm_nss_sync.sv
// Two-flop synchronizer for a framing strobe plus a delay flop for falling-edge detect.
module nss_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic fall
);

    // sync_q[0], sync_q[1] synchronize; sync_q[2] holds the previous synchronized value.
    logic [2:0] sync_q, sync_d;

    // Shift the raw input through the chain.
    always_comb begin
        sync_d = {sync_q[1:0], async_in};
    end

    // Chain idles high so reset never fakes a falling edge.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= 3'b111;
        else     sync_q <= sync_d;
    end

    assign fall = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/roll_servo_pwm.sv
// Captures framed roll words, clamps/scales them to a pulse width and drives servo PWM.
module roll_servo_pwm
    import servo_pkg::*;
#(
    parameter int PERIOD_CYCLES   = PERIOD_CYCLES_DEF,
    parameter int CENTER_CYCLES   = CENTER_CYCLES_DEF,
    parameter int GAIN            = GAIN_DEF,
    parameter int ROLL_LIM        = ROLL_LIM_DEF,
    parameter int TIMEOUT_PERIODS = TIMEOUT_PERIODS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nss,
    input  logic [15:0] roll,
    output logic        pwm,
    output logic        stale,
    output logic        word_stb
);

    localparam int TO_W = $clog2(TIMEOUT_PERIODS + 1);

    logic                      fall;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [WIDTH_W-1:0]        active_q, active_d;
    logic [15:0]               pending_q, pending_d;
    logic                      fresh_q, fresh_d;
    logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
    logic                      stale_q, stale_d;
    logic                      pwm_q, pwm_d;
    logic                      word_stb_q, word_stb_d;

    roll_t                     roll_c;
    logic signed [WIDTH_W-1:0] c_ext;
    logic signed [WIDTH_W-1:0] width;
    logic                      boundary;

    nss_sync u_nss_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (nss),
        .fall     (fall)
    );

    // Clamp and scale the pending word; always lands inside the period.
    always_comb begin
        roll_c = clamp_roll(roll_t'(pending_q), ROLL_LIM);
        c_ext  = {{(WIDTH_W-16){roll_c[15]}}, roll_c};
        width  = WIDTH_W'(CENTER_CYCLES) + c_ext * WIDTH_W'(GAIN);
    end

    assign boundary = (cnt_q == CNT_W'(PERIOD_CYCLES - 1));

    // Period counter, boundary update of the applied width, timeout and capture.
    always_comb begin
        cnt_d      = boundary ? '0 : cnt_q + CNT_W'(1);
        active_d   = active_q;
        pending_d  = pending_q;
        fresh_d    = fresh_q;
        to_cnt_d   = to_cnt_q;
        stale_d    = stale_q;
        pwm_d      = ({{(WIDTH_W-CNT_W){1'b0}}, cnt_q} < active_q);
        word_stb_d = fall;

        // Boundary acts on fresh/pending as they stood before this cycle.
        if (boundary) begin
            fresh_d = 1'b0;
            if (fresh_q) begin
                active_d = unsigned'(width);
                stale_d  = 1'b0;
                to_cnt_d = '0;
            end else begin
                if (to_cnt_q != TO_W'(TIMEOUT_PERIODS))
                    to_cnt_d = to_cnt_q + TO_W'(1);
                if (to_cnt_d == TO_W'(TIMEOUT_PERIODS)) begin
                    active_d = WIDTH_W'(CENTER_CYCLES);
                    stale_d  = 1'b1;
                end
            end
        end

        // A capture overrides the boundary's fresh clear and timeout increment.
        if (fall) begin
            pending_d = roll;
            fresh_d   = 1'b1;
            to_cnt_d  = '0;
        end
    end

    // State registers; reset restarts the period at centre width.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            active_q   <= WIDTH_W'(CENTER_CYCLES);
            pending_q  <= '0;
            fresh_q    <= 1'b0;
            to_cnt_q   <= '0;
            stale_q    <= 1'b1;
            pwm_q      <= 1'b0;
            word_stb_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            fresh_q    <= fresh_d;
            to_cnt_q   <= to_cnt_d;
            stale_q    <= stale_d;
            pwm_q      <= pwm_d;
            word_stb_q <= word_stb_d;
        end
    end

    assign pwm      = pwm_q;
    assign stale    = stale_q;
    assign word_stb = word_stb_q;

endmodule

// File: tb/tb_roll_servo_pwm.sv
// Period-level check of roll_servo_pwm with small sim parameters.
module tb_roll_servo_pwm;

    localparam int P    = 100;
    localparam int CEN  = 50;
    localparam int LIM  = 20;
    localparam int TOUT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nss = 1'b1;
    logic [15:0] roll = '0;
    logic        pwm, stale, word_stb;

    roll_servo_pwm #(
        .PERIOD_CYCLES   (P),
        .CENTER_CYCLES   (CEN),
        .GAIN            (1),
        .ROLL_LIM        (LIM),
        .TIMEOUT_PERIODS (TOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .nss      (nss),
        .roll     (roll),
        .pwm      (pwm),
        .stale    (stale),
        .word_stb (word_stb)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int t        = 0;       // cycles since reset release; cnt == t % P
    int rise_t   = 0;

    // Model: widths scheduled per period index, last capture wins.
    bit sched_v [0:255];
    int sched_w [0:255];
    int last_cap;
    int exp_w;
    bit exp_stale;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int ew(input int r);
        logic signed [15:0] rs;
        int c;
        rs = r[15:0];
        c  = rs;
        if (c > LIM)  c = LIM;
        if (c < -LIM) c = -LIM;
        return CEN + c;
    endfunction

    function automatic int rnd_roll();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 65535));
        return int'($urandom_range(0, 50)) - 25;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
        if (!nss && t >= rise_t) nss = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            sched_v[i] = 1'b0;
            sched_w[i] = 0;
        end
        last_cap  = -1;
        exp_w     = CEN;
        exp_stale = 1'b1;
    endtask

    // Drop nss with a new word; the word is live in the DUT 3 edges later.
    task automatic capture(input int r, output int stb_t);
        int ap;
        roll   = r[15:0];
        nss    = 1'b0;
        rise_t = t + 5;
        stb_t  = t + 3;
        ap     = (t + 3) / P + 1;
        sched_v[ap] = 1'b1;
        sched_w[ap] = r;
    endtask

    // Run one full period from t % P == 0, optionally capturing words at offsets o1/o2.
    task automatic run_period(input int o1, input int r1, input int o2, input int r2);
        int n, hi, stbs, ncap, e1, e2;
        n = t / P;
        if (sched_v[n]) begin
            exp_w     = ew(sched_w[n]);
            exp_stale = 1'b0;
            last_cap  = n - 1;
        end else if (n - 1 - last_cap >= TOUT) begin
            exp_w     = CEN;
            exp_stale = 1'b1;
        end
        hi = 0; stbs = 0; ncap = 0; e1 = -1; e2 = -1;
        for (int i = 0; i < P; i++) begin
            if (o1 >= 0 && (t % P) == o1) begin capture(r1, e1); ncap++; end
            if (o2 >= 0 && (t % P) == o2) begin capture(r2, e2); ncap++; end
            tick();
            hi   += int'(pwm);
            stbs += int'(word_stb);
            if (i == 0) check($sformatf("stale_p%0d", n), 32'(stale), 32'(exp_stale));
            if (t == e1 || t == e2) check($sformatf("stb_lat_p%0d", n), 32'(word_stb), 32'd1);
        end
        check($sformatf("width_p%0d", n), 32'(hi), 32'(exp_w));
        check($sformatf("stb_cnt_p%0d", n), 32'(stbs), 32'(ncap));
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        nss  = 1'b1;
        tick(); tick();
        check("rst_pwm", 32'(pwm), 32'd0);
        check("rst_stale", 32'(stale), 32'd1);
        check("rst_stb", 32'(word_stb), 32'd0);
        rst = 1'b0;
        t   = 0;
        model_reset();
    endtask

    initial begin
        do_reset();

        // Idle: centre and stale through and past the timeout.
        for (int p = 0; p < 4; p++) run_period(-1, 0, -1, 0);

        // Word 10 then silence: 60 for three periods, then back to centre.
        run_period(30, 16'h000A, -1, 0);
        for (int p = 0; p < 4; p++) run_period(-1, 0, -1, 0);

        // Clamp limits.
        run_period(25, 16'h7FFF, -1, 0);
        run_period(60, 16'h8000, -1, 0);
        run_period(10, 16'hFFEC, -1, 0);

        // Capture lands on the boundary cycle: applied one period later.
        run_period(P - 3, 5, -1, 0);
        run_period(-1, 0, -1, 0);

        // Two words in one period: last wins.
        run_period(10, 3, 40, -7);
        run_period(-1, 0, -1, 0);

        // Randomized words and gaps.
        for (int p = 0; p < 14; p++) begin
            int k;
            k = int'($urandom_range(0, 2));
            if (k == 0)      run_period(-1, 0, -1, 0);
            else if (k == 1) run_period(int'($urandom_range(0, 90)), rnd_roll(), -1, 0);
            else             run_period(int'($urandom_range(0, 40)), rnd_roll(),
                                        int'($urandom_range(50, 90)), rnd_roll());
        end

        // Reset in the middle of a 60-cycle pulse.
        run_period(20, 16'h000A, -1, 0);
        while ((t % P) != 20) tick();
        check("pre_rst_pwm", 32'(pwm), 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_pwm", 32'(pwm), 32'd0);
        check("mid_rst_stale", 32'(stale), 32'd1);
        rst = 1'b0;
        t   = 0;
        model_reset();
        run_period(-1, 0, -1, 0);
        run_period(-1, 0, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
